// File: rtl/cluster_pwr_seq_pkg.sv
// Shared types and defaults for the cluster power/boot sequencer.
package cluster_pwr_seq_pkg;

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    PWR_UP     = 3'd1,
    RST_HOLD   = 3'd2,
    RUN        = 3'd3,
    DRAIN      = 3'd4,
    RST_ASSERT = 3'd5,
    CLK_GATE   = 3'd6
  } cluster_seq_state_e;

  localparam int DEF_PWR_UP_CYCLES   = 16;
  localparam int DEF_RST_HOLD_CYCLES = 8;
  localparam int DEF_CLK_GATE_CYCLES = 4;
  localparam int DEF_DRAIN_TIMEOUT   = 1024;

  // Cluster control bundle, MSB first: pow, clk_en, rstn, fetch.
  typedef struct packed {
    logic pow;
    logic clk_en;
    logic rstn;
    logic fetch;
  } cluster_ctrl_t;

  // Largest of four cycle counts, used to size the shared counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Control levels driven to the cluster in each sequencer state.
  function automatic cluster_ctrl_t ctrl_for_state(input cluster_seq_state_e st);
    cluster_ctrl_t c;
    c = '0;
    case (st)
      PWR_UP:     c = 4'b1000;
      RST_HOLD:   c = 4'b1100;
      RUN:        c = 4'b1111;
      DRAIN:      c = 4'b1110;
      RST_ASSERT: c = 4'b1100;
      CLK_GATE:   c = 4'b1000;
      default:    c = 4'b0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cluster_seq_timer.sv
// Loadable down-counter that parks at zero; zero_o marks the last cycle of a timed state.
module cluster_seq_timer #(
  parameter int CNT_WIDTH = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  output logic                 zero_o
);

  logic [CNT_WIDTH-1:0] cnt_reg;

  // Load on state entry, otherwise count down and hold at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (load_i) begin
      cnt_reg <= load_val_i;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_WIDTH'(1);
    end
  end

  assign zero_o = (cnt_reg == '0);

endmodule

// File: rtl/cluster_pwr_seq.sv
// Cluster power/boot sequencer: timed Moore FSM driving power, clock, reset and fetch enable.
module cluster_pwr_seq
  import cluster_pwr_seq_pkg::*;
#(
  parameter int PWR_UP_CYCLES   = DEF_PWR_UP_CYCLES,
  parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int CLK_GATE_CYCLES = DEF_CLK_GATE_CYCLES,
  parameter int DRAIN_TIMEOUT   = DEF_DRAIN_TIMEOUT,
  parameter int CNT_WIDTH       = $clog2(max4(PWR_UP_CYCLES, RST_HOLD_CYCLES,
                                              CLK_GATE_CYCLES, DRAIN_TIMEOUT)) + 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_on_i,
  input  logic        req_off_i,
  input  logic [63:0] boot_addr_i,
  input  logic        cluster_busy_i,
  output logic        cluster_pow_o,
  output logic        cluster_clk_en_o,
  output logic        cluster_rstn_o,
  output logic        cluster_fetch_enable_o,
  output logic [63:0] cluster_boot_addr_o,
  output logic        on_o,
  output logic        idle_o,
  output logic        evt_o,
  output logic        timeout_o,
  output logic [2:0]  state_o
);

  cluster_seq_state_e   state_reg, state_next;
  logic                 rev_pend_reg, rev_pend_next;
  logic [63:0]          boot_addr_reg;
  cluster_ctrl_t        ctrl_reg;
  logic                 on_reg, idle_reg, evt_reg, timeout_reg;
  logic                 timeout_next, capture, cnt_zero, cnt_load;
  logic [CNT_WIDTH-1:0] cnt_load_val;
  logic                 on_only, off_only;

  cluster_seq_timer #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  // A lone request counts toward rev_pend; both together are treated as no request.
  assign on_only  = req_on_i & ~req_off_i;
  assign off_only = req_off_i & ~req_on_i;

  // Next-state, reverse-pending bookkeeping and counter reload on timed-state entry.
  always_comb begin
    state_next    = state_reg;
    rev_pend_next = rev_pend_reg;
    timeout_next  = 1'b0;
    capture       = 1'b0;
    cnt_load      = 1'b0;
    cnt_load_val  = '0;
    case (state_reg)
      OFF: begin
        if (req_on_i || rev_pend_reg) begin
          state_next    = PWR_UP;
          capture       = 1'b1;
          rev_pend_next = 1'b0;
        end
      end
      PWR_UP, RST_HOLD: begin
        if (off_only)     rev_pend_next = 1'b1;
        else if (on_only) rev_pend_next = 1'b0;
        if (cnt_zero) state_next = (state_reg == PWR_UP) ? RST_HOLD : RUN;
      end
      RUN: begin
        if (req_off_i || rev_pend_reg) begin
          state_next    = DRAIN;
          rev_pend_next = 1'b0;
        end
      end
      DRAIN: begin
        if (on_only)       rev_pend_next = 1'b1;
        else if (off_only) rev_pend_next = 1'b0;
        // An idle cluster wins over an expiring counter on the same cycle.
        if (!cluster_busy_i || cnt_zero) begin
          state_next   = RST_ASSERT;
          timeout_next = cluster_busy_i;
        end
      end
      RST_ASSERT, CLK_GATE: begin
        if (on_only)       rev_pend_next = 1'b1;
        else if (off_only) rev_pend_next = 1'b0;
        if (cnt_zero) state_next = (state_reg == RST_ASSERT) ? CLK_GATE : OFF;
      end
      default: state_next = OFF;
    endcase

    if (state_next != state_reg) begin
      cnt_load = 1'b1;
      case (state_next)
        PWR_UP:             cnt_load_val = CNT_WIDTH'(PWR_UP_CYCLES - 1);
        RST_HOLD, RST_ASSERT: cnt_load_val = CNT_WIDTH'(RST_HOLD_CYCLES - 1);
        DRAIN:              cnt_load_val = CNT_WIDTH'(DRAIN_TIMEOUT - 1);
        CLK_GATE:           cnt_load_val = CNT_WIDTH'(CLK_GATE_CYCLES - 1);
        default:            cnt_load_val = '0;
      endcase
    end
  end

  // State, pending bit, boot address and outputs registered from the next state,
  // so reset forces every output (idle included) to 0 until it is released.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= OFF;
      rev_pend_reg  <= 1'b0;
      boot_addr_reg <= '0;
      ctrl_reg      <= '0;
      on_reg        <= 1'b0;
      idle_reg      <= 1'b0;
      evt_reg       <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rev_pend_reg <= rev_pend_next;
      if (capture) boot_addr_reg <= boot_addr_i;
      ctrl_reg     <= ctrl_for_state(state_next);
      on_reg       <= (state_next == RUN);
      idle_reg     <= (state_next == OFF);
      evt_reg      <= (state_next != state_reg) && ((state_next == RUN) || (state_next == OFF));
      timeout_reg  <= timeout_next;
    end
  end

  assign cluster_pow_o          = ctrl_reg.pow;
  assign cluster_clk_en_o       = ctrl_reg.clk_en;
  assign cluster_rstn_o         = ctrl_reg.rstn;
  assign cluster_fetch_enable_o = ctrl_reg.fetch;
  assign cluster_boot_addr_o    = boot_addr_reg;
  assign on_o                   = on_reg;
  assign idle_o                 = idle_reg;
  assign evt_o                  = evt_reg;
  assign timeout_o              = timeout_reg;
  assign state_o                = state_reg;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Self-checking bench for cluster_pwr_seq: expected per-cycle traces built from phase tables.
module tb_cluster_pwr_seq;

  localparam int PU = 16;
  localparam int RH = 8;
  localparam int CG = 4;
  localparam int DT = 1024;
  localparam int S_OFF = 0, S_PU = 1, S_RH = 2, S_RUN = 3, S_DR = 4, S_RA = 5, S_CG = 6;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_on_i = 1'b0;
  logic        req_off_i = 1'b0;
  logic [63:0] boot_addr_i = '0;
  logic        cluster_busy_i = 1'b0;
  logic        cluster_pow_o, cluster_clk_en_o, cluster_rstn_o, cluster_fetch_enable_o;
  logic [63:0] cluster_boot_addr_o;
  logic        on_o, idle_o, evt_o, timeout_o;
  logic [2:0]  state_o;

  logic [63:0] exp_addr = '0;
  int          checks = 0;
  int          failures = 0;
  int          ncyc = 0;
  logic [10:0] log_mem [0:65535];
  logic [10:0] exp_q [$];

  cluster_pwr_seq dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .req_on_i               (req_on_i),
    .req_off_i              (req_off_i),
    .boot_addr_i            (boot_addr_i),
    .cluster_busy_i         (cluster_busy_i),
    .cluster_pow_o          (cluster_pow_o),
    .cluster_clk_en_o       (cluster_clk_en_o),
    .cluster_rstn_o         (cluster_rstn_o),
    .cluster_fetch_enable_o (cluster_fetch_enable_o),
    .cluster_boot_addr_o    (cluster_boot_addr_o),
    .on_o                   (on_o),
    .idle_o                 (idle_o),
    .evt_o                  (evt_o),
    .timeout_o              (timeout_o),
    .state_o                (state_o)
  );

  always #5 clk = ~clk;

  // Observation log, sampled mid-cycle: {state, timeout, evt, idle, on, fetch, rstn, clk_en, pow}.
  always @(negedge clk) begin
    log_mem[ncyc[15:0]] = {state_o, timeout_o, evt_o, idle_o, on_o,
                           cluster_fetch_enable_o, cluster_rstn_o, cluster_clk_en_o, cluster_pow_o};
    ncyc = ncyc + 1;
  end

  // Control levels per state from the state table, {fetch, rstn, clk_en, pow}.
  function automatic logic [3:0] spec_ctrl(input int st);
    case (st)
      S_PU:    return 4'b0001;
      S_RH:    return 4'b0011;
      S_RUN:   return 4'b1111;
      S_DR:    return 4'b0111;
      S_RA:    return 4'b0011;
      S_CG:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_phase(input int st, input int len, input bit evt1, input bit to1);
    logic [10:0] e;
    for (int i = 0; i < len; i++) begin
      e = {3'(st), (to1 && (i == 0)), (evt1 && (i == 0)), (st == S_OFF), (st == S_RUN), spec_ctrl(st)};
      exp_q.push_back(e);
    end
  endtask

  task automatic push_up(input int run_len);
    push_phase(S_PU, PU, 1'b0, 1'b0);
    push_phase(S_RH, RH, 1'b0, 1'b0);
    push_phase(S_RUN, run_len, 1'b1, 1'b0);
  endtask

  task automatic push_down(input int drain_len, input bit to, input int off_len);
    push_phase(S_DR, drain_len, 1'b0, 1'b0);
    push_phase(S_RA, RH, 1'b0, to);
    push_phase(S_CG, CG, 1'b0, 1'b0);
    push_phase(S_OFF, off_len, 1'b1, 1'b0);
  endtask

  task automatic wait_trace(input int base);
    int guard;
    guard = 0;
    while ((ncyc < base + exp_q.size()) && (guard < 5000)) begin
      @(posedge clk);
      guard++;
    end
    #1;
  endtask

  function automatic int trace_diff(input int base);
    for (int i = 0; i < exp_q.size(); i++)
      if (log_mem[16'(base + i)] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic go_run();
    exp_addr = {$urandom, $urandom};
    boot_addr_i = exp_addr;
    req_on_i = 1'b1;
    tick();
    req_on_i = 1'b0;
    repeat (PU + RH + 1) tick();
  endtask

  task automatic go_off();
    cluster_busy_i = 1'b0;
    req_off_i = 1'b1;
    tick();
    req_off_i = 1'b0;
    repeat (RH + CG + 4) tick();
  endtask

  task automatic test_reset();
    logic [74:0] obs;
    repeat (3) tick();
    obs = {cluster_pow_o, cluster_clk_en_o, cluster_rstn_o, cluster_fetch_enable_o,
           on_o, idle_o, evt_o, timeout_o, state_o, cluster_boot_addr_o};
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_outputs got %h expected 0", obs);
    end
    rst_i = 1'b0;
    tick();
    checks++;
    if ({idle_o, evt_o, cluster_pow_o, state_o} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_release got idle/evt/pow/state=%b expected 100000",
               {idle_o, evt_o, cluster_pow_o, state_o});
    end
    $display("txn reset: idle=%0b state=%0d", idle_o, state_o);
  endtask

  task automatic test_power_up();
    int base, bad;
    exp_addr = {$urandom, $urandom};
    repeat ($urandom_range(1, 5)) tick();
    boot_addr_i = exp_addr;
    req_on_i = 1'b1;
    tick();
    req_on_i = 1'b0;
    boot_addr_i = ~exp_addr;
    base = ncyc;
    exp_q.delete();
    push_up(5);
    wait_trace(base);
    bad = trace_diff(base);
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL power_up_trace cycle %0d got %b expected %b", bad, log_mem[16'(base + bad)], exp_q[bad]);
    end
    checks++;
    if (cluster_boot_addr_o !== exp_addr) begin
      failures++;
      $display("FAIL power_up_addr got %h expected %h", cluster_boot_addr_o, exp_addr);
    end
    $display("txn power_up: addr=%h", exp_addr);
  endtask

  // From RUN: busy held for busy_cycles DRAIN cycles, then dropped.
  task automatic test_drain(input int busy_cycles, input string name);
    int base, bad, d, n_to, n_dr;
    bit to;
    to = (busy_cycles >= DT);
    d  = to ? DT : busy_cycles + 1;
    exp_q.delete();
    push_down(d, to, 3);
    cluster_busy_i = (busy_cycles > 0);
    req_off_i = 1'b1;
    tick();
    req_off_i = 1'b0;
    base = ncyc;
    repeat ((busy_cycles > DT + 6) ? DT + 6 : busy_cycles) tick();
    cluster_busy_i = 1'b0;
    wait_trace(base);
    bad = trace_diff(base);
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s_trace cycle %0d got %b expected %b", name, bad, log_mem[16'(base + bad)], exp_q[bad]);
    end
    n_to = 0;
    n_dr = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (log_mem[16'(base + i)][7]) n_to++;
      if (log_mem[16'(base + i)][10:8] == 3'(S_DR)) n_dr++;
    end
    checks++;
    if (n_to != int'(to) || n_dr != d) begin
      failures++;
      $display("FAIL %s_count got timeouts=%0d drain=%0d expected timeouts=%0d drain=%0d",
               name, n_to, n_dr, int'(to), d);
    end
    checks++;
    if (cluster_boot_addr_o !== exp_addr) begin
      failures++;
      $display("FAIL %s_addr_kept got %h expected %h", name, cluster_boot_addr_o, exp_addr);
    end
    $display("txn %s: busy_cycles=%0d drain=%0d timeout=%0b", name, busy_cycles, d, to);
  endtask

  task automatic test_rev_up(input int p);
    int base, bad;
    exp_addr = {$urandom, $urandom};
    boot_addr_i = exp_addr;
    cluster_busy_i = 1'b0;
    req_on_i = 1'b1;
    tick();
    req_on_i = 1'b0;
    base = ncyc;
    exp_q.delete();
    push_up(1);
    push_down(1, 1'b0, 3);
    repeat (p - 1) tick();
    req_off_i = 1'b1;
    tick();
    req_off_i = 1'b0;
    wait_trace(base);
    bad = trace_diff(base);
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL rev_up_trace p=%0d cycle %0d got %b expected %b", p, bad, log_mem[16'(base + bad)], exp_q[bad]);
    end
    $display("txn rev_up: req_off at up-cycle %0d", p);
  endtask

  task automatic test_rev_cancel(input int p, input int q);
    int base, bad;
    exp_addr = {$urandom, $urandom};
    boot_addr_i = exp_addr;
    req_on_i = 1'b1;
    tick();
    req_on_i = 1'b0;
    base = ncyc;
    exp_q.delete();
    push_up(8);
    repeat (p - 1) tick();
    req_off_i = 1'b1;
    tick();
    req_off_i = 1'b0;
    repeat (q - p - 1) tick();
    req_on_i = 1'b1;
    tick();
    req_on_i = 1'b0;
    wait_trace(base);
    bad = trace_diff(base);
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL rev_cancel_trace cycle %0d got %b expected %b", bad, log_mem[16'(base + bad)], exp_q[bad]);
    end
    $display("txn rev_cancel: off at %0d, on at %0d", p, q);
    go_off();
  endtask

  task automatic test_simultaneous();
    int base, bad, p, q, cur;
    bit r;
    r = 1'($urandom_range(0, 1));
    p = $urandom_range(1, PU);
    q = $urandom_range(PU + 1, PU + RH);
    exp_addr = {$urandom, $urandom};
    boot_addr_i = exp_addr;
    cluster_busy_i = 1'b0;
    req_on_i = 1'b1;
    req_off_i = 1'b1;
    tick();
    req_on_i = 1'b0;
    req_off_i = 1'b0;
    base = ncyc;
    cur = 1;
    exp_q.delete();
    if (r) begin
      push_up(1);
      push_down(1, 1'b0, 3);
      repeat (p - cur) tick();
      req_off_i = 1'b1;
      tick();
      req_off_i = 1'b0;
      cur = p + 1;
    end else begin
      push_up(6);
    end
    repeat (q - cur) tick();
    req_on_i = 1'b1;
    req_off_i = 1'b1;
    tick();
    req_on_i = 1'b0;
    req_off_i = 1'b0;
    wait_trace(base);
    bad = trace_diff(base);
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL simul_up_trace rev=%0b cycle %0d got %b expected %b", r, bad, log_mem[16'(base + bad)], exp_q[bad]);
    end
    $display("txn simultaneous_up: prior_rev=%0b both at %0d", r, q);
    if (!r) begin
      req_on_i = 1'b1;
      req_off_i = 1'b1;
      tick();
      req_on_i = 1'b0;
      req_off_i = 1'b0;
      base = ncyc;
      exp_q.delete();
      push_down(1, 1'b0, 3);
      wait_trace(base);
      bad = trace_diff(base);
      checks++;
      if (bad >= 0) begin
        failures++;
        $display("FAIL simul_run_trace cycle %0d got %b expected %b", bad, log_mem[16'(base + bad)], exp_q[bad]);
      end
      $display("txn simultaneous_run: both high in RUN");
    end
  endtask

  task automatic test_rev_down(input int p);
    int base, bad;
    logic [63:0] a1, a2;
    a1 = {$urandom, $urandom};
    a2 = ~a1 ^ {$urandom, $urandom};
    cluster_busy_i = 1'b0;
    req_off_i = 1'b1;
    tick();
    req_off_i = 1'b0;
    base = ncyc;
    exp_q.delete();
    push_down(1, 1'b0, 1);
    push_up(3);
    repeat (p - 1) tick();
    req_on_i = 1'b1;
    boot_addr_i = a1;
    tick();
    req_on_i = 1'b0;
    boot_addr_i = a2;
    wait_trace(base);
    bad = trace_diff(base);
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL rev_down_trace p=%0d cycle %0d got %b expected %b", p, bad, log_mem[16'(base + bad)], exp_q[bad]);
    end
    checks++;
    if (cluster_boot_addr_o !== a2) begin
      failures++;
      $display("FAIL rev_down_addr got %h expected %h", cluster_boot_addr_o, a2);
    end
    exp_addr = a2;
    $display("txn rev_down: req_on at down-cycle %0d addr=%h", p, a2);
  endtask

  task automatic test_reset_mid();
    int base, c, n_act;
    logic [74:0] obs;
    c = $urandom_range(PU + 1, PU + RH);
    boot_addr_i = {$urandom, $urandom};
    req_on_i = 1'b1;
    tick();
    req_on_i = 1'b0;
    repeat (2) tick();
    req_off_i = 1'b1;
    tick();
    req_off_i = 1'b0;
    repeat (c - 4) tick();
    rst_i = 1'b1;
    tick();
    obs = {cluster_pow_o, cluster_clk_en_o, cluster_rstn_o, cluster_fetch_enable_o,
           on_o, idle_o, evt_o, timeout_o, state_o, cluster_boot_addr_o};
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got %h expected 0", obs);
    end
    rst_i = 1'b0;
    tick();
    checks++;
    if ({idle_o, evt_o, cluster_pow_o, state_o} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_mid_release got idle/evt/pow/state=%b expected 100000",
               {idle_o, evt_o, cluster_pow_o, state_o});
    end
    base = ncyc;
    repeat (30) tick();
    n_act = 0;
    for (int i = 0; i < 29; i++)
      if (log_mem[16'(base + i)][0] || log_mem[16'(base + i)][6]) n_act++;
    checks++;
    if (n_act != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet got %0d active cycles expected 0", n_act);
    end
    $display("txn reset_mid: reset at up-cycle %0d", c);
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_drain(0, "clean_down");
    go_run();
    test_drain(50, "busy50");
    go_run();
    test_drain($urandom_range(1, 300), "busy_rand");
    go_run();
    test_drain(DT - 1, "busy_edge");
    go_run();
    test_drain(5000, "busy_stuck");
    test_rev_up(3);
    repeat (3) test_rev_up($urandom_range(1, PU + RH));
    test_rev_cancel(3, $urandom_range(4, PU + RH));
    test_simultaneous();
    test_simultaneous();
    go_run();
    test_rev_down($urandom_range(1, 1 + RH + CG));
    go_off();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
